// File: rtl/pipe_hazard_unit_if.sv
// pipe_hazard_unit_if: ID operands, redirect/memory-wait inputs and stall/flush/forward outputs of the hazard unit
interface pipe_hazard_unit_if #(
    parameter int AW = 5,
    parameter int CW = 32
);
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [AW-1:0] id_rd;
    logic          id_regwr;
    logic          id_load;
    logic          redirect;
    logic          mem_busy;
    logic          stall_pc;
    logic          stall_ifid;
    logic          flush_ifid;
    logic          flush_idex;
    logic          flush_exm;
    logic [1:0]    fwd_a_sel;
    logic [1:0]    fwd_b_sel;
    logic [1:0]    hz_state;
    logic [CW-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwr, id_load, redirect, mem_busy,
        input  stall_pc, stall_ifid, flush_ifid, flush_idex, flush_exm, fwd_a_sel, fwd_b_sel, hz_state, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwr, id_load, redirect, mem_busy,
        output stall_pc, stall_ifid, flush_ifid, flush_idex, flush_exm, fwd_a_sel, fwd_b_sel, hz_state, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: stall/flush/forward/freeze control for the 5-stage RV32 pipeline; define HAZARD_FWD_EN to build EX operand forwarding
module pipe_hazard_unit #(
    parameter int AW        = 5,
    parameter int BR_STAGE  = 2,
    parameter int WB_BYPASS = 0,
    parameter int CW        = 32
) (
    input logic               CLK,
    input logic               Resetn,
    pipe_hazard_unit_if.slave hz
);
    typedef enum logic [1:0] {RUN = 2'b00, DSTALL = 2'b01, FREEZE = 2'b10} state_t;
    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          regwr;
        logic          load;
    } slot_t;

    slot_t         ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    state_t        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          u1, u2, hit_ex, hit_wb, data_hz, frz, redir, dstall;

    function automatic logic match(slot_t s, logic [AW-1:0] r);
        return s.v & s.regwr & (s.rd == r) & (r != '0);
    endfunction

    function automatic logic id_hit(slot_t s, logic a, logic [AW-1:0] ra, logic b, logic [AW-1:0] rb);
        return (a & match(s, ra)) | (b & match(s, rb));
    endfunction

    assign u1     = hz.id_valid & hz.id_use_rs1;
    assign u2     = hz.id_valid & hz.id_use_rs2;
    assign hit_ex = id_hit(ex_q, u1, hz.id_rs1, u2, hz.id_rs2);
    assign hit_wb = (WB_BYPASS == 0) && id_hit(wb_q, u1, hz.id_rs1, u2, hz.id_rs2);

`ifdef HAZARD_FWD_EN
    typedef struct packed {
        logic          u1;
        logic          u2;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
    } src_t;

    src_t src_q;

    function automatic logic [1:0] fwd(logic u, logic [AW-1:0] r, slot_t m, slot_t w);
        return !u ? 2'b00 : (match(m, r) & !m.load) ? 2'b01 : match(w, r) ? 2'b10 : 2'b00;
    endfunction

    // only a load in EX cannot be forwarded in time; WB still needs a stall when reads precede writes
    assign data_hz      = (hit_ex & ex_q.load) | hit_wb;
    assign hz.fwd_a_sel = fwd(ex_q.v & src_q.u1, src_q.r1, mem_q, wb_q);
    assign hz.fwd_b_sel = fwd(ex_q.v & src_q.u2, src_q.r2, mem_q, wb_q);

    // EX operand record tracks the EX slot; a bubble's stale sources are masked by ex_q.v
    always_ff @(posedge CLK or negedge Resetn)
        if (!Resetn) src_q <= '0;
        else if (!frz) src_q <= {hz.id_use_rs1, hz.id_use_rs2, hz.id_rs1, hz.id_rs2};
`else
    logic hit_mem;

    // without forwarding every in-flight producer blocks the consumer until it retires
    assign hit_mem      = id_hit(mem_q, u1, hz.id_rs1, u2, hz.id_rs2);
    assign data_hz      = hit_ex | hit_mem | hit_wb;
    assign hz.fwd_a_sel = 2'b00;
    assign hz.fwd_b_sel = 2'b00;
`endif

    assign frz           = hz.mem_busy;
    assign redir         = hz.redirect & !frz;
    assign dstall        = data_hz & !redir & !frz;
    assign hz.stall_pc   = frz | dstall;
    assign hz.stall_ifid = frz | dstall;
    assign hz.flush_ifid = redir;
    assign hz.flush_idex = !frz & (data_hz | redir);
    assign hz.flush_exm  = (BR_STAGE == 2) && redir;
    assign hz.hz_state   = st_q;
    assign hz.stall_cnt  = cnt_q;

    // shadow slots advance unless frozen; EX takes ID only when neither stalled nor squashed
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!frz) begin
            wb_d  = mem_q;
            mem_d = (redir && BR_STAGE == 2) ? '0 : ex_q;
            ex_d  = (hz.id_valid & !data_hz & !redir) ? {1'b1, hz.id_rd, hz.id_regwr, hz.id_load} : '0;
        end
    end

    // state reports the previous cycle's condition; the counter saturates instead of wrapping
    always_comb begin
        st_d  = frz ? FREEZE : dstall ? DSTALL : RUN;
        cnt_d = (dstall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // slot, state and counter registers
    always_ff @(posedge CLK or negedge Resetn)
        if (!Resetn) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            st_q  <= RUN;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed scoreboard bench for pipe_hazard_unit (BR_STAGE=2, WB_BYPASS=0, CW=2), with or without HAZARD_FWD_EN
module tb_pipe_hazard_unit;
    localparam logic [1:0] R = 2'd0, D = 2'd1, F = 2'd2;

    typedef struct {
        string       tag;
        logic [12:0] v;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    pipe_hazard_unit_if #(.AW(5), .CW(2)) bus ();

    pipe_hazard_unit #(.AW(5), .BR_STAGE(2), .WB_BYPASS(0), .CW(2)) dut (
        .CLK   (clk),
        .Resetn(rst_n),
        .hz    (bus)
    );

    always #5 clk = ~clk;

    task automatic id(input logic v, input logic [4:0] rd, input logic wr, ld,
                      input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
        bus.id_valid   = v;
        bus.id_rd      = rd;
        bus.id_regwr   = wr;
        bus.id_load    = ld;
        bus.id_rs1     = r1;
        bus.id_use_rs1 = u1;
        bus.id_rs2     = r2;
        bus.id_use_rs2 = u2;
    endtask

    task automatic alu(input logic [4:0] rd, r1, r2);
        id(1'b1, rd, 1'b1, 1'b0, r1, 1'b1, r2, 1'b1);
    endtask

    task automatic lw(input logic [4:0] rd, r1);
        id(1'b1, rd, 1'b1, 1'b1, r1, 1'b1, 5'd0, 1'b0);
    endtask

    task automatic nop();
        id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic expect_out(input string tag, input logic st, fi, fe, fx, input logic [1:0] fa, fb, hs, cnt);
        exp_t e;
        e.tag = tag;
        e.v   = {st, st, fi, fe, fx, fa, fb, hs, cnt};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [12:0] obs;
        e   = sb.pop_front();
        obs = {bus.stall_pc, bus.stall_ifid, bus.flush_ifid, bus.flush_idex, bus.flush_exm,
               bus.fwd_a_sel, bus.fwd_b_sel, bus.hz_state, bus.stall_cnt};
        n_assert++;
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (stpc,stif,fif,fide,fexm,fa,fb,hz,cnt)", e.tag, obs, e.v);
        end
    endtask

    // one cycle: outputs sampled at the falling edge, inputs for the next cycle driven #1 after the rising edge
    task automatic step(input string tag, input logic st, fi, fe, fx, input logic [1:0] fa, fb, hs, cnt);
        expect_out(tag, st, fi, fe, fx, fa, fb, hs, cnt);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nop();
        bus.redirect = 1'b0;
        bus.mem_busy = 1'b0;
        rst_n = 1'b0;
        #1;
        expect_out("reset", 0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        check();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // WB-slot producer with read-before-write regfile stalls one cycle in both builds
        alu(5'd5, 5'd1, 5'd2); step("wb_a",     0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        nop();                 step("wb_b",     0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        nop();                 step("wb_c",     0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        alu(5'd6, 5'd5, 5'd3); step("wb_stall", 1, 0, 1, 0, 2'b00, 2'b00, R, 2'd0);
                               step("wb_go",    0, 0, 0, 0, 2'b00, 2'b00, D, 2'd1);
        nop();                 step("wb_idle",  0, 0, 0, 0, 2'b00, 2'b00, R, 2'd1);
        do_reset();

`ifdef HAZARD_FWD_EN
        // load-use: one stall then WB forward
        lw(5'd5, 5'd1);        step("t1_a",   0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        alu(5'd6, 5'd5, 5'd1); step("t1_lu",  1, 0, 1, 0, 2'b00, 2'b00, R, 2'd0);
                               step("t1_go",  0, 0, 0, 0, 2'b00, 2'b00, D, 2'd1);
        nop();                 step("t1_fwd", 0, 0, 0, 0, 2'b10, 2'b00, R, 2'd1);
        // MEM beats WB for the same destination
        alu(5'd5, 5'd1, 5'd2); step("t2_a",   0, 0, 0, 0, 2'b00, 2'b00, R, 2'd1);
        alu(5'd5, 5'd3, 5'd4); step("t2_b",   0, 0, 0, 0, 2'b00, 2'b00, R, 2'd1);
        alu(5'd7, 5'd5, 5'd5); step("t2_c",   0, 0, 0, 0, 2'b00, 2'b00, R, 2'd1);
        nop();                 step("t2_fwd", 0, 0, 0, 0, 2'b01, 2'b01, R, 2'd1);
        do_reset();
        // chained loads: four load-use stalls saturate the 2-bit counter
        lw(5'd5, 5'd1);        step("s_a",  0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        lw(5'd6, 5'd5);        step("s1",   1, 0, 1, 0, 2'b00, 2'b00, R, 2'd0);
                               step("s1g",  0, 0, 0, 0, 2'b00, 2'b00, D, 2'd1);
        lw(5'd7, 5'd6);        step("s2",   1, 0, 1, 0, 2'b10, 2'b00, R, 2'd1);
                               step("s2g",  0, 0, 0, 0, 2'b00, 2'b00, D, 2'd2);
        lw(5'd8, 5'd7);        step("s3",   1, 0, 1, 0, 2'b10, 2'b00, R, 2'd2);
                               step("s3g",  0, 0, 0, 0, 2'b00, 2'b00, D, 2'd3);
        alu(5'd9, 5'd8, 5'd8); step("s4",   1, 0, 1, 0, 2'b10, 2'b00, R, 2'd3);
                               step("s4g",  0, 0, 0, 0, 2'b00, 2'b00, D, 2'd3);
`else
        // no forwarding: producer blocks through EX, MEM and WB (x0 source never matches)
        alu(5'd5, 5'd1, 5'd2); step("t3_a",    0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        alu(5'd6, 5'd5, 5'd0); step("t3_ex",   1, 0, 1, 0, 2'b00, 2'b00, R, 2'd0);
                               step("t3_mem",  1, 0, 1, 0, 2'b00, 2'b00, D, 2'd1);
                               step("t3_wb",   1, 0, 1, 0, 2'b00, 2'b00, D, 2'd2);
                               step("t3_go",   0, 0, 0, 0, 2'b00, 2'b00, D, 2'd3);
        alu(5'd7, 5'd6, 5'd1); step("sat_ex",  1, 0, 1, 0, 2'b00, 2'b00, R, 2'd3);
                               step("sat_mem", 1, 0, 1, 0, 2'b00, 2'b00, D, 2'd3);
                               step("sat_wb",  1, 0, 1, 0, 2'b00, 2'b00, D, 2'd3);
                               step("sat_go",  0, 0, 0, 0, 2'b00, 2'b00, D, 2'd3);
`endif
        do_reset();

        // redirect from MEM squashes EX and ID; squashed destinations never match later
        alu(5'd5, 5'd1, 5'd2);  step("r_a",     0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        alu(5'd7, 5'd3, 5'd4);  step("r_b",     0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        alu(5'd8, 5'd9, 5'd10); bus.redirect = 1'b1;
                                step("r_flush", 0, 1, 1, 1, 2'b00, 2'b00, R, 2'd0);
        bus.redirect = 1'b0;
        alu(5'd9, 5'd7, 5'd8);  step("r_after", 0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        nop();                  step("r_fwd",   0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        // redirect overrides a load-use stall
        lw(5'd5, 5'd1);         step("ro_a",    0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        alu(5'd6, 5'd5, 5'd1);  bus.redirect = 1'b1;
                                step("ro_ovr",  0, 1, 1, 1, 2'b00, 2'b00, R, 2'd0);
        bus.redirect = 1'b0;
        nop();                  step("ro_idle", 0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        do_reset();

        // memory wait during a load-use stall freezes everything and ignores redirect
        lw(5'd5, 5'd1);        step("f_a",  0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        alu(5'd6, 5'd5, 5'd1); bus.mem_busy = 1'b1;
                               step("f_b",  1, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        bus.redirect = 1'b1;   step("f_c",  1, 0, 0, 0, 2'b00, 2'b00, F, 2'd0);
                               step("f_d",  1, 0, 0, 0, 2'b00, 2'b00, F, 2'd0);
        bus.redirect = 1'b0;   step("f_e",  1, 0, 0, 0, 2'b00, 2'b00, F, 2'd0);
        bus.mem_busy = 1'b0;   step("f_lu", 1, 0, 1, 0, 2'b00, 2'b00, F, 2'd0);
`ifdef HAZARD_FWD_EN
                               step("f_go",  0, 0, 0, 0, 2'b00, 2'b00, D, 2'd1);
        nop();                 step("f_fwd", 0, 0, 0, 0, 2'b10, 2'b00, R, 2'd1);
`else
                               step("f_mem", 1, 0, 1, 0, 2'b00, 2'b00, D, 2'd1);
                               step("f_wb",  1, 0, 1, 0, 2'b00, 2'b00, D, 2'd2);
                               step("f_go",  0, 0, 0, 0, 2'b00, 2'b00, D, 2'd3);
`endif
        do_reset();

        // x0 destination is never a hazard or forward source
        alu(5'd0, 5'd1, 5'd2); step("z_a", 0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        alu(5'd1, 5'd0, 5'd0); step("z_b", 0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        nop();                 step("z_c", 0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        do_reset();

        // asynchronous reset in the middle of a data stall
        lw(5'd5, 5'd1);        step("m_a",  0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        alu(5'd6, 5'd5, 5'd1); step("m_lu", 1, 0, 1, 0, 2'b00, 2'b00, R, 2'd0);
        expect_out("reset_mid", 0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);
        rst_n = 1'b0;
        #1;
        check();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_reset", 0, 0, 0, 0, 2'b00, 2'b00, R, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
